// File: rtl/dac_sample_scheduler_if.sv
// Handshake bundle between the sample scheduler, the sample sources, the
// state controller and the SPI DAC output controller.
interface dac_sample_scheduler_if;
    logic [4:0]  currentState;
    logic [11:0] keysSample;
    logic [11:0] songSample;
    logic [11:0] recordingSample;
    logic        keysValid;
    logic        songValid;
    logic        recordingValid;
    logic [2:0]  sampleRequest;
    logic [1:0]  activeSource;
    logic [11:0] dacSample;
    logic        dacSendSample_n;
    logic        dacIsBusy;
    logic        dacTransmitComplete;
    logic [7:0]  underrunCount;
    logic [7:0]  missedTickCount;

    modport master (
        input  currentState,
        input  keysSample, songSample, recordingSample,
        input  keysValid, songValid, recordingValid,
        input  dacIsBusy, dacTransmitComplete,
        output sampleRequest, activeSource, dacSample, dacSendSample_n,
        output underrunCount, missedTickCount
    );

    modport slave (
        output currentState,
        output keysSample, songSample, recordingSample,
        output keysValid, songValid, recordingValid,
        output dacIsBusy, dacTransmitComplete,
        input  sampleRequest, activeSource, dacSample, dacSendSample_n,
        input  underrunCount, missedTickCount
    );
endinterface

// File: rtl/dac_sample_scheduler.sv
// Sample-rate scheduler: generates the sample tick, picks the active source,
// fetches one sample per tick and hands it to the SPI DAC controller.
module dac_sample_scheduler #(
    parameter int unsigned CLOCKS_PER_SAMPLE = 32'd2500,
    parameter int unsigned TIMEOUT_CLOCKS    = 32'd2000,
    parameter logic [11:0] MIDSCALE          = 12'd2048
) (
    input  logic                   clock_50Mhz,
    input  logic                   reset,
    dac_sample_scheduler_if.master sched_if
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQUEST   = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_WAIT_DAC  = 3'd3,
        ST_SENDING   = 3'd4
    } state_t;

    localparam logic [1:0]  SRC_KEYS     = 2'd0;
    localparam logic [1:0]  SRC_SONG     = 2'd1;
    localparam logic [1:0]  SRC_REC      = 2'd2;
    localparam logic [1:0]  SRC_SILENCE  = 2'd3;
    localparam logic [15:0] TICK_LAST    = 16'(CLOCKS_PER_SAMPLE - 32'd1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLOCKS - 32'd1);

    function automatic logic [1:0] decode_source(input logic [4:0] st);
        logic [1:0] src;
        case (st)
            5'd0, 5'd3: src = SRC_KEYS;
            5'd1, 5'd2: src = SRC_SONG;
            5'd4:       src = SRC_REC;
            default:    src = SRC_SILENCE;
        endcase
        return src;
    endfunction

    function automatic logic [2:0] request_mask(input logic [1:0] src);
        logic [2:0] mask;
        case (src)
            SRC_KEYS: mask = 3'b001;
            SRC_SONG: mask = 3'b010;
            SRC_REC:  mask = 3'b100;
            default:  mask = 3'b000;
        endcase
        return mask;
    endfunction

    state_t      state_q;
    logic [15:0] tick_cnt_q;
    logic [15:0] tick_cnt_d;
    logic [15:0] timer_q;
    logic [1:0]  active_q;
    logic [11:0] sample_q;
    logic [2:0]  request_q;
    logic        send_n_q;
    logic [7:0]  underrun_q;
    logic [7:0]  missed_q;
    logic        tick_s;
    logic [1:0]  next_src_s;
    logic        src_valid_s;
    logic [11:0] src_data_s;

    // Free-running sample tick counter next state.
    always_comb begin
        tick_s = (tick_cnt_q == TICK_LAST);
        if (tick_s) begin
            tick_cnt_d = 16'd0;
        end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    // Only the source latched at the tick is listened to.
    always_comb begin
        next_src_s = decode_source(sched_if.currentState);
        case (active_q)
            SRC_KEYS: begin
                src_valid_s = sched_if.keysValid;
                src_data_s  = sched_if.keysSample;
            end
            SRC_SONG: begin
                src_valid_s = sched_if.songValid;
                src_data_s  = sched_if.songSample;
            end
            SRC_REC: begin
                src_valid_s = sched_if.recordingValid;
                src_data_s  = sched_if.recordingSample;
            end
            default: begin
                src_valid_s = 1'b0;
                src_data_s  = MIDSCALE;
            end
        endcase
    end

    // Tick counter register.
    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= 16'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Transaction FSM with registered strobes and saturating event counters.
    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= 16'd0;
            active_q   <= SRC_SILENCE;
            sample_q   <= MIDSCALE;
            request_q  <= 3'b000;
            send_n_q   <= 1'b1;
            underrun_q <= 8'd0;
            missed_q   <= 8'd0;
        end else begin
            request_q <= 3'b000;
            send_n_q  <= 1'b1;
            if (tick_s && (state_q != ST_IDLE) && (missed_q != 8'hFF)) begin
                missed_q <= missed_q + 8'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick_s) begin
                        active_q <= next_src_s;
                        // A source change presets midscale so an early underrun never replays stale audio.
                        if ((next_src_s == SRC_SILENCE) || (next_src_s != active_q)) begin
                            sample_q <= MIDSCALE;
                        end
                        if (next_src_s != SRC_SILENCE) begin
                            request_q <= request_mask(next_src_s);
                            state_q   <= ST_REQUEST;
                        end else if (!sched_if.dacIsBusy) begin
                            send_n_q <= 1'b0;
                            timer_q  <= 16'd0;
                            state_q  <= ST_SENDING;
                        end else begin
                            state_q <= ST_WAIT_DAC;
                        end
                    end
                end
                ST_REQUEST: begin
                    timer_q <= 16'd0;
                    state_q <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (src_valid_s || (timer_q == TIMEOUT_LAST)) begin
                        if (src_valid_s) begin
                            sample_q <= src_data_s;
                        end else if (underrun_q != 8'hFF) begin
                            underrun_q <= underrun_q + 8'd1;
                        end
                        if (!sched_if.dacIsBusy) begin
                            send_n_q <= 1'b0;
                            timer_q  <= 16'd0;
                            state_q  <= ST_SENDING;
                        end else begin
                            state_q <= ST_WAIT_DAC;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                ST_WAIT_DAC: begin
                    if (!sched_if.dacIsBusy) begin
                        send_n_q <= 1'b0;
                        timer_q  <= 16'd0;
                        state_q  <= ST_SENDING;
                    end
                end
                ST_SENDING: begin
                    if (sched_if.dacTransmitComplete || (timer_q == TIMEOUT_LAST)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sched_if.sampleRequest   = request_q;
    assign sched_if.activeSource    = active_q;
    assign sched_if.dacSample       = sample_q;
    assign sched_if.dacSendSample_n = send_n_q;
    assign sched_if.underrunCount   = underrun_q;
    assign sched_if.missedTickCount = missed_q;
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed-plus-random bench: sources and DAC are emulated, and every send
// strobe and request is compared against an event-level timing model.
module tb_dac_sample_scheduler;
    localparam int          CPS = 100;
    localparam int          TMO = 20;
    localparam logic [11:0] MID = 12'd2048;

    typedef struct {
        int          x;
        int          st;
        int          d;
        logic [11:0] data;
        int          cd;
    } tick_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    dac_sample_scheduler_if sif();

    dac_sample_scheduler #(
        .CLOCKS_PER_SAMPLE(CPS),
        .TIMEOUT_CLOCKS(TMO),
        .MIDSCALE(MID)
    ) dut (
        .clock_50Mhz(clk),
        .reset(reset),
        .sched_if(sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Emulator knobs and state
    int          cur_d = 0, cur_cd = 0, noise_en = 0;
    logic [11:0] cur_data = 12'd0;
    int          busy_lo = 1, busy_hi = 0;
    int          lat = 3, vcnt = 0, vsrc = 0, ccnt = 0;
    logic [11:0] vdata = 12'd0;

    // Observations and expectations
    int          obs_send_cyc[$];
    logic [11:0] obs_send_val[$];
    int          obs_req_cyc[$];
    logic [2:0]  obs_req_val[$];
    int          exp_send_cyc[$];
    logic [11:0] exp_send_val[$];
    int          exp_req_cyc[$];
    logic [2:0]  exp_req_val[$];
    tick_t       ticks[$];

    int          m_prev_src, m_idle_from, m_under, m_missed;
    logic [11:0] m_sample;
    int          next_x, phase_x0, first_send;
    logic [2:0]  first_req;

    function automatic bit busy_at(input int c);
        return (c >= busy_lo) && (c <= busy_hi);
    endfunction

    function automatic int src_of(input int st);
        if (st == 0 || st == 3) return 0;
        if (st == 1 || st == 2) return 1;
        if (st == 4) return 2;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_valid(input int s, input logic [11:0] v);
        case (s)
            0: begin sif.keysValid = 1'b1; sif.keysSample = v; end
            1: begin sif.songValid = 1'b1; sif.songSample = v; end
            default: begin sif.recordingValid = 1'b1; sif.recordingSample = v; end
        endcase
    endtask

    // Sources answer a request after cur_d cycles; the DAC completes cur_cd cycles after a send.
    initial begin
        sif.keysValid = 1'b0; sif.songValid = 1'b0; sif.recordingValid = 1'b0;
        sif.keysSample = 12'd0; sif.songSample = 12'd0; sif.recordingSample = 12'd0;
        sif.dacIsBusy = 1'b0; sif.dacTransmitComplete = 1'b0;
        forever begin
            @(negedge clk);
            sif.keysValid = 1'b0; sif.songValid = 1'b0; sif.recordingValid = 1'b0;
            sif.dacTransmitComplete = 1'b0;
            sif.keysSample = 12'($urandom);
            sif.songSample = 12'($urandom);
            sif.recordingSample = 12'($urandom);
            if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) drive_valid(vsrc, vdata);
            end
            if (sif.sampleRequest != 3'b000) begin
                lat = sif.sampleRequest[0] ? 0 : (sif.sampleRequest[1] ? 1 : 2);
                if (cur_d > 0) begin vcnt = cur_d; vsrc = lat; vdata = cur_data; end
            end
            if (noise_en != 0) begin
                for (int j = 0; j < 3; j++)
                    if (j != lat && $urandom_range(0, 3) == 0) drive_valid(j, 12'($urandom));
            end
            sif.dacIsBusy = busy_at(cyc);
            if (ccnt > 0) begin
                ccnt--;
                if (ccnt == 0) sif.dacTransmitComplete = 1'b1;
            end
            if (sif.dacSendSample_n == 1'b0 && cur_cd > 0) ccnt = cur_cd;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (sif.dacSendSample_n !== 1'b1) begin
                obs_send_cyc.push_back(cyc);
                obs_send_val.push_back(sif.dacSample);
            end
            if (sif.sampleRequest !== 3'b000) begin
                obs_req_cyc.push_back(cyc);
                obs_req_val.push_back(sif.sampleRequest);
            end
        end
    end

    task automatic clear_queues();
        obs_send_cyc.delete(); obs_send_val.delete(); obs_req_cyc.delete(); obs_req_val.delete();
        exp_send_cyc.delete(); exp_send_val.delete(); exp_req_cyc.delete(); exp_req_val.delete();
        ticks.delete();
    endtask

    task automatic model_reset();
        m_prev_src = 3; m_sample = MID; m_idle_from = 0; m_under = 0; m_missed = 0;
        clear_queues();
    endtask

    // Event-level model: when the send happens, what it carries, when the scheduler is free again.
    task automatic model_tick(input tick_t t);
        int src, ready, s;
        if (t.x < m_idle_from) begin
            if (m_missed < 255) m_missed++;
            return;
        end
        src = src_of(t.st);
        if (src != m_prev_src) m_sample = MID;
        m_prev_src = src;
        if (src == 3) begin
            m_sample = MID;
            ready = t.x + 1;
        end else begin
            exp_req_cyc.push_back(t.x + 1);
            exp_req_val.push_back(3'(1 << src));
            if (t.d >= 1 && t.d <= TMO) begin
                m_sample = t.data;
                ready = t.x + 2 + t.d;
            end else begin
                if (m_under < 255) m_under++;
                ready = t.x + 2 + TMO;
            end
        end
        s = ready;
        while (busy_at(s - 1)) s++;
        exp_send_cyc.push_back(s);
        exp_send_val.push_back(m_sample);
        m_idle_from = (t.cd >= 1 && t.cd < TMO) ? s + t.cd + 1 : s + TMO;
    endtask

    task automatic compare_phase(input string tag);
        int n;
        foreach (ticks[i]) model_tick(ticks[i]);
        check({tag, "_send_count"}, obs_send_cyc.size(), exp_send_cyc.size());
        n = (obs_send_cyc.size() < exp_send_cyc.size()) ? obs_send_cyc.size() : exp_send_cyc.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_send_cycle"}, obs_send_cyc[i], exp_send_cyc[i]);
            check({tag, "_send_sample"}, obs_send_val[i], exp_send_val[i]);
        end
        check({tag, "_req_count"}, obs_req_cyc.size(), exp_req_cyc.size());
        n = (obs_req_cyc.size() < exp_req_cyc.size()) ? obs_req_cyc.size() : exp_req_cyc.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_req_cycle"}, obs_req_cyc[i], exp_req_cyc[i]);
            check({tag, "_req_mask"}, obs_req_val[i], exp_req_val[i]);
        end
        check({tag, "_active_source"}, sif.activeSource, m_prev_src);
        check({tag, "_underrun"}, sif.underrunCount, m_under);
        check({tag, "_missed"}, sif.missedTickCount, m_missed);
        check({tag, "_dac_sample"}, sif.dacSample, m_sample);
        first_send = (obs_send_cyc.size() > 0) ? obs_send_cyc[0] : -1;
        first_req  = (obs_req_val.size() > 0) ? obs_req_val[0] : 3'b000;
        clear_queues();
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // st/d/cd < 0 select random values; busy window and switch point are relative to the first tick.
    task automatic run_phase(input string tag, input int n, input int st, input int d,
                             input logic [11:0] data, input int cd, input int blo, input int bhi,
                             input int noise, input int sw_at, input int sw_st);
        tick_t t;
        int    r;
        phase_x0 = next_x;
        for (int k = 0; k < n; k++) begin
            t.x = next_x;
            next_x += CPS;
            wait_cycle(t.x - 5);
            r = $urandom_range(0, 5);
            t.st = (st >= 0) ? st : ((r < 5) ? r : $urandom_range(5, 31));
            r = $urandom_range(0, 9);
            t.d = (d >= 0) ? d : ((r == 0) ? 0 : $urandom_range(1, 24));
            t.data = (d >= 0) ? data : 12'($urandom);
            r = $urandom_range(0, 7);
            t.cd = (cd >= 0) ? cd : ((r == 0) ? 0 : $urandom_range(1, 19));
            sif.currentState = 5'(t.st);
            cur_d = t.d; cur_data = t.data; cur_cd = t.cd; noise_en = noise;
            if (k == 0) begin busy_lo = t.x + blo; busy_hi = t.x + bhi; end
            ticks.push_back(t);
            if (k == 0 && sw_at > 0) begin
                wait_cycle(t.x + sw_at);
                sif.currentState = 5'(sw_st);
            end
        end
        wait_cycle(next_x - CPS + 60);
        compare_phase(tag);
        busy_lo = 1; busy_hi = 0; noise_en = 0;
    endtask

    initial begin
        int x;
        reset = 1'b1;
        sif.currentState = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_send_n", sif.dacSendSample_n, 1'b1);
        check("rst_dac_sample", sif.dacSample, MID);
        check("rst_request", sif.sampleRequest, 3'b000);
        check("rst_active_source", sif.activeSource, 2'd3);
        check("rst_underrun", sif.underrunCount, 8'd0);
        check("rst_missed", sif.missedTickCount, 8'd0);
        reset = 1'b0;
        model_reset();
        next_x = cyc + CPS - 1;

        run_phase("keys", 4, 0, 1, 12'h3A5, 10, 1, 0, 0, 0, 0);
        check("keys_sample_const", sif.dacSample, 12'h3A5);
        check("keys_underrun_zero", sif.underrunCount, 8'd0);

        run_phase("underrun1", 1, 1, 0, 12'd0, 10, 1, 0, 0, 0, 0);
        check("underrun_send_offset", first_send - phase_x0, 22);
        check("underrun_count1", sif.underrunCount, 8'd1);
        check("underrun_midscale", sif.dacSample, MID);
        run_phase("underrun5", 4, 1, 0, 12'd0, 10, 1, 0, 0, 0, 0);
        check("underrun_count5", sif.underrunCount, 8'd5);

        run_phase("silence", 3, 7, 0, 12'd0, 10, 1, 0, 0, 0, 0);
        check("silence_source", sif.activeSource, 2'd3);

        run_phase("backpressure", 3, 0, 1, 12'h5C3, 10, 1, 150, 0, 0, 0);
        check("backpressure_missed", sif.missedTickCount, 8'd1);

        run_phase("switch_old", 1, 1, 3, 12'h1B7, 10, 2, 30, 0, 10, 4);
        run_phase("switch_new", 1, 4, 2, 12'hE21, 10, 1, 0, 0, 0, 0);
        check("switch_req_mask", first_req, 3'b100);
        check("switch_source", sif.activeSource, 2'd2);

        run_phase("valid_at_timeout", 1, 0, 20, 12'h0F1, 10, 1, 0, 0, 0, 0);
        run_phase("valid_after_timeout", 1, 0, 21, 12'h7E7, 10, 1, 0, 0, 0, 0);

        run_phase("random", 30, -1, -1, 12'd0, -1, 1, 0, 1, 0, 0);

        run_phase("underrun_sat", 256, 2, 0, 12'd0, 5, 1, 0, 0, 0, 0);
        check("underrun_saturated", sif.underrunCount, 8'd255);
        run_phase("missed_sat", 263, 0, 1, 12'h2D4, 10, 1, 26000, 0, 0, 0);
        check("missed_saturated", sif.missedTickCount, 8'd255);

        // Reset in the middle of a send.
        x = next_x;
        wait_cycle(x - 5);
        sif.currentState = 5'd0; cur_d = 1; cur_data = 12'h456; cur_cd = 15;
        wait_cycle(x + 6);
        check("pre_reset_send_cycle", (obs_send_cyc.size() > 0) ? obs_send_cyc[obs_send_cyc.size() - 1] : -1, x + 3);
        #1 reset = 1'b1;
        #1;
        check("async_send_n", sif.dacSendSample_n, 1'b1);
        check("async_dac_sample", sif.dacSample, MID);
        check("async_underrun", sif.underrunCount, 8'd0);
        check("async_missed", sif.missedTickCount, 8'd0);
        check("async_source", sif.activeSource, 2'd3);
        check("async_request", sif.sampleRequest, 3'b000);
        repeat (3) @(negedge clk);
        sif.currentState = 5'd7;
        reset = 1'b0;
        model_reset();
        x = cyc;
        next_x = x + CPS - 1;
        run_phase("post_reset", 2, 7, 0, 12'd0, 10, 1, 0, 0, 0, 0);
        check("post_reset_first_send", first_send - x, CPS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
